// File: rtl/irq_pending_latch.sv
// Interrupt front end: synchronises eight request lines, latches them as pending bits,
// feeds the masked vector to an external priority encoder and offers its index via valid/ready.
module irq_pending_latch #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  output logic [7:0] pend_vec,
  input  logic [2:0] enc_idx,
  output logic       req_valid,
  output logic [2:0] req_idx,
  input  logic       req_ready,
  input  logic       eoi,
  output logic [7:0] pending,
  output logic [7:0] in_service
);

  localparam int LAST = SYNC_STAGES - 1;

  typedef enum logic [1:0] {IDLE, OFFER, SERVICE} state_t;

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] sync_d [SYNC_STAGES];
  logic [7:0] prev_q, prev_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] in_service_q, in_service_d;
  logic       req_valid_q, req_valid_d;
  logic [2:0] req_idx_q, req_idx_d;
  state_t     state_q, state_d;

  logic [7:0] set_vec;
  logic [7:0] sel_vec;
  logic       hs;

  assign pend_vec   = pending_q & ~mask;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign req_valid  = req_valid_q;
  assign req_idx    = req_idx_q;

  always_comb begin
    sync_d[0] = irq_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d  = sync_q[LAST];
    set_vec = EDGE ? (sync_q[LAST] & ~prev_q) : sync_q[LAST];

    sel_vec = 8'(1) << req_idx_q;
    hs      = req_valid_q & req_ready;

    // A set arriving in the handshake cycle wins over the clear of the same bit.
    pending_d = (pending_q & ~(hs ? sel_vec : 8'h00)) | set_vec;

    state_d      = state_q;
    req_valid_d  = req_valid_q;
    req_idx_d    = req_idx_q;
    in_service_d = in_service_q;

    case (state_q)
      IDLE: begin
        if (|pend_vec) begin
          req_idx_d   = enc_idx;
          req_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (req_ready) begin
          in_service_d = sel_vec;
          req_valid_d  = 1'b0;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          in_service_d = 8'h00;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        req_valid_d  = 1'b0;
        in_service_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 8'h00;
      end
      prev_q       <= 8'h00;
      pending_q    <= 8'h00;
      in_service_q <= 8'h00;
      req_valid_q  <= 1'b0;
      req_idx_q    <= 3'd0;
      state_q      <= IDLE;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      req_valid_q  <= req_valid_d;
      req_idx_q    <= req_idx_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: an edge-mode instance (a) and a level-mode instance (b),
// each fed by a behavioural 8:3 priority encoder; offered indices are scoreboarded.
module tb_irq_pending_latch;

  logic       clk;
  logic       rst_n;

  logic [7:0] irq_a, mask_a, pend_vec_a, pending_a, in_service_a;
  logic [2:0] enc_a, req_idx_a;
  logic       req_valid_a, ready_a, eoi_a;

  logic [7:0] irq_b, mask_b, pend_vec_b, pending_b, in_service_b;
  logic [2:0] enc_b, req_idx_b;
  logic       req_valid_b, ready_b, eoi_b;

  int         passed;
  int         total;
  logic [2:0] exp_q[$];
  logic [2:0] exp_idx;

  irq_pending_latch #(.SYNC_STAGES(2), .EDGE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_a), .mask(mask_a), .pend_vec(pend_vec_a),
    .enc_idx(enc_a), .req_valid(req_valid_a), .req_idx(req_idx_a), .req_ready(ready_a),
    .eoi(eoi_a), .pending(pending_a), .in_service(in_service_a)
  );

  irq_pending_latch #(.SYNC_STAGES(2), .EDGE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_b), .mask(mask_b), .pend_vec(pend_vec_b),
    .enc_idx(enc_b), .req_valid(req_valid_b), .req_idx(req_idx_b), .req_ready(ready_b),
    .eoi(eoi_b), .pending(pending_b), .in_service(in_service_b)
  );

  // Priority encoders: index 7 highest.
  always_comb begin
    enc_a = 3'd0;
    for (int i = 0; i < 8; i++) if (pend_vec_a[i]) enc_a = 3'(i);
  end

  always_comb begin
    enc_b = 3'd0;
    for (int i = 0; i < 8; i++) if (pend_vec_b[i]) enc_b = 3'(i);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid_a(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (req_valid_a) begin
        ok = 1'b1;
        return;
      end
      cycle();
    end
    ok = req_valid_a;
  endtask

  task automatic wait_valid_b(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (req_valid_b) begin
        ok = 1'b1;
        return;
      end
      cycle();
    end
    ok = req_valid_b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    irq_a = 8'h00; mask_a = 8'hFF; ready_a = 1'b0; eoi_a = 1'b0;
    irq_b = 8'h00; mask_b = 8'h00; ready_b = 1'b0; eoi_b = 1'b0;
    cycle(); cycle();
    total++; if (req_valid_a !== 1'b0) $display("FAIL reset_valid got=%b exp=0", req_valid_a); else passed++;
    total++; if (req_idx_a !== 3'd0) $display("FAIL reset_idx got=%0d exp=0", req_idx_a); else passed++;
    total++; if (pending_a !== 8'h00) $display("FAIL reset_pending got=%h exp=00", pending_a); else passed++;
    total++; if (in_service_a !== 8'h00) $display("FAIL reset_in_service got=%h exp=00", in_service_a); else passed++;
    total++; if (pend_vec_a !== 8'h00) $display("FAIL reset_pend_vec got=%h exp=00", pend_vec_a); else passed++;
    rst_n  = 1'b1;
    mask_a = 8'h00;
    cycle();
  endtask

  task automatic test_single();
    ready_a = 1'b1;
    irq_a = 8'h08;
    cycle();              // edge 1: first sample
    irq_a = 8'h00;
    cycle();              // edge 2
    cycle();              // edge 3: pending set
    total++; if (pending_a !== 8'h08) $display("FAIL single_pending got=%h exp=08", pending_a); else passed++;
    total++; if (pend_vec_a !== 8'h08) $display("FAIL single_pend_vec got=%h exp=08", pend_vec_a); else passed++;
    total++; if (req_valid_a !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", req_valid_a); else passed++;
    exp_q.push_back(3'd3);
    cycle();              // edge 4: offer
    exp_idx = exp_q.pop_front();
    total++; if (req_valid_a !== 1'b1) $display("FAIL single_valid got=%b exp=1", req_valid_a); else passed++;
    total++; if (req_idx_a !== exp_idx) $display("FAIL single_idx got=%0d exp=%0d", req_idx_a, exp_idx); else passed++;
    cycle();              // edge 5: handshake
    total++; if (pending_a !== 8'h00) $display("FAIL single_clear got=%h exp=00", pending_a); else passed++;
    total++; if (in_service_a !== 8'h08) $display("FAIL single_in_service got=%h exp=08", in_service_a); else passed++;
    total++; if (req_valid_a !== 1'b0) $display("FAIL single_valid_drop got=%b exp=0", req_valid_a); else passed++;
    eoi_a = 1'b1; cycle(); eoi_a = 1'b0;
    total++; if (in_service_a !== 8'h00) $display("FAIL single_eoi got=%h exp=00", in_service_a); else passed++;
    cycle();
  endtask

  task automatic test_priority();
    bit ok;
    ready_a = 1'b1;
    irq_a = 8'h44;
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd2);
    cycle();
    irq_a = 8'h00;
    wait_valid_a(10, ok);
    total++; if (!ok) $display("FAIL prio_timeout got=no_offer exp=offer"); else passed++;
    exp_idx = exp_q.pop_front();
    total++; if (req_idx_a !== exp_idx) $display("FAIL prio_first got=%0d exp=%0d", req_idx_a, exp_idx); else passed++;
    cycle();
    total++; if (in_service_a !== 8'h40) $display("FAIL prio_svc6 got=%h exp=40", in_service_a); else passed++;
    total++; if (pending_a !== 8'h04) $display("FAIL prio_pending got=%h exp=04", pending_a); else passed++;
    eoi_a = 1'b1; cycle(); eoi_a = 1'b0;
    cycle();
    exp_idx = exp_q.pop_front();
    total++; if (req_valid_a !== 1'b1) $display("FAIL prio_second_valid got=%b exp=1", req_valid_a); else passed++;
    total++; if (req_idx_a !== exp_idx) $display("FAIL prio_second got=%0d exp=%0d", req_idx_a, exp_idx); else passed++;
    cycle();
    total++; if (in_service_a !== 8'h04) $display("FAIL prio_svc2 got=%h exp=04", in_service_a); else passed++;
    eoi_a = 1'b1; cycle(); eoi_a = 1'b0;
    total++; if (pending_a !== 8'h00) $display("FAIL prio_end_pending got=%h exp=00", pending_a); else passed++;
    cycle();
  endtask

  task automatic test_no_preempt();
    bit ok;
    ready_a = 1'b0;
    irq_a = 8'h04;
    exp_q.push_back(3'd2);
    cycle();
    irq_a = 8'h00;
    wait_valid_a(10, ok);
    total++; if (!ok) $display("FAIL hold_timeout got=no_offer exp=offer"); else passed++;
    irq_a = 8'h80;
    cycle();
    irq_a = 8'h00;
    repeat (5) cycle();
    total++; if (req_valid_a !== 1'b1) $display("FAIL hold_valid got=%b exp=1", req_valid_a); else passed++;
    exp_idx = exp_q.pop_front();
    total++; if (req_idx_a !== exp_idx) $display("FAIL hold_idx got=%0d exp=%0d", req_idx_a, exp_idx); else passed++;
    total++; if (pending_a !== 8'h84) $display("FAIL hold_pending got=%h exp=84", pending_a); else passed++;
    exp_q.push_back(3'd7);
    ready_a = 1'b1;
    cycle();
    total++; if (in_service_a !== 8'h04) $display("FAIL hold_svc got=%h exp=04", in_service_a); else passed++;
    total++; if (pending_a !== 8'h80) $display("FAIL hold_after_hs got=%h exp=80", pending_a); else passed++;
    eoi_a = 1'b1; cycle(); eoi_a = 1'b0;
    cycle();
    exp_idx = exp_q.pop_front();
    total++; if (req_idx_a !== exp_idx || req_valid_a !== 1'b1)
      $display("FAIL hold_next got=%0d/%b exp=%0d/1", req_idx_a, req_valid_a, exp_idx); else passed++;
    cycle();
    eoi_a = 1'b1; cycle(); eoi_a = 1'b0;
  endtask

  task automatic test_mask();
    mask_a  = 8'h10;
    ready_a = 1'b1;
    irq_a = 8'h10;
    cycle();
    irq_a = 8'h00;
    repeat (5) cycle();
    total++; if (pending_a !== 8'h10) $display("FAIL mask_pending got=%h exp=10", pending_a); else passed++;
    total++; if (pend_vec_a !== 8'h00) $display("FAIL mask_pend_vec got=%h exp=00", pend_vec_a); else passed++;
    total++; if (req_valid_a !== 1'b0) $display("FAIL mask_valid got=%b exp=0", req_valid_a); else passed++;
    mask_a = 8'h00;
    exp_q.push_back(3'd4);
    cycle();
    exp_idx = exp_q.pop_front();
    total++; if (req_valid_a !== 1'b1 || req_idx_a !== exp_idx)
      $display("FAIL mask_release got=%b/%0d exp=1/%0d", req_valid_a, req_idx_a, exp_idx); else passed++;
    cycle();
    eoi_a = 1'b1; cycle(); eoi_a = 1'b0;
  endtask

  task automatic test_level();
    bit ok;
    ready_b = 1'b1;
    irq_b = 8'h02;
    exp_q.push_back(3'd1);
    wait_valid_b(10, ok);
    total++; if (!ok) $display("FAIL level_timeout got=no_offer exp=offer"); else passed++;
    exp_idx = exp_q.pop_front();
    total++; if (req_idx_b !== exp_idx) $display("FAIL level_idx got=%0d exp=%0d", req_idx_b, exp_idx); else passed++;
    cycle();
    total++; if (pending_b !== 8'h02) $display("FAIL level_set_wins got=%h exp=02", pending_b); else passed++;
    total++; if (in_service_b !== 8'h02) $display("FAIL level_svc got=%h exp=02", in_service_b); else passed++;
    eoi_b = 1'b1; cycle(); eoi_b = 1'b0;
    exp_q.push_back(3'd1);
    cycle();
    exp_idx = exp_q.pop_front();
    total++; if (req_valid_b !== 1'b1 || req_idx_b !== exp_idx)
      $display("FAIL level_reoffer got=%b/%0d exp=1/%0d", req_valid_b, req_idx_b, exp_idx); else passed++;
    irq_b = 8'h00;
    ready_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int offers;
    ready_a = 1'b1;
    irq_a = 8'h20;
    exp_q.push_back(3'd5);
    wait_valid_a(10, ok);
    total++; if (!ok) $display("FAIL rstmid_timeout got=no_offer exp=offer"); else passed++;
    exp_idx = exp_q.pop_front();
    total++; if (req_idx_a !== exp_idx) $display("FAIL rstmid_idx got=%0d exp=%0d", req_idx_a, exp_idx); else passed++;
    cycle();
    total++; if (in_service_a !== 8'h20) $display("FAIL rstmid_svc got=%h exp=20", in_service_a); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (in_service_a !== 8'h00 || req_valid_a !== 1'b0 || pending_a !== 8'h00 || pend_vec_a !== 8'h00)
      $display("FAIL rstmid_async got=%h/%b/%h/%h exp=00/0/00/00", in_service_a, req_valid_a, pending_a, pend_vec_a);
    else passed++;
    cycle(); cycle();
    rst_n = 1'b1;
    exp_q.push_back(3'd5);
    wait_valid_a(10, ok);
    total++; if (!ok) $display("FAIL rstmid_reoffer_timeout got=no_offer exp=offer"); else passed++;
    exp_idx = exp_q.pop_front();
    total++; if (req_idx_a !== exp_idx) $display("FAIL rstmid_reoffer got=%0d exp=%0d", req_idx_a, exp_idx); else passed++;
    cycle();
    eoi_a = 1'b1; cycle(); eoi_a = 1'b0;
    offers = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_valid_a) offers++;
      cycle();
    end
    total++; if (offers !== 0) $display("FAIL rstmid_extra_offers got=%0d exp=0", offers); else passed++;
    total++; if (pending_a !== 8'h00) $display("FAIL rstmid_pending got=%h exp=00", pending_a); else passed++;
    irq_a = 8'h00;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_mask();
    test_level();
    test_reset_mid();
    total++; if (exp_q.size() !== 0) $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Interrupt front end that sits directly upstream of the 8:3 priority encoder. It synchronises eight asynchronous request lines, latches them as pending bits, and drives the masked pending vector into the encoder's 8-bit data input. It takes the encoder's 3-bit index back and offers it to the CPU-side consumer through a valid/ready handshake. It tracks the in-service request until end-of-interrupt. Index 7 has the highest priority and index 0 the lowest, matching the encoder.

## Interface
- SYNC_STAGES, 2, number of synchroniser flops per request line; minimum 2.
- EDGE, 1, detection mode: 1 = a rising edge sets the pending bit; 0 = a high level sets it every cycle.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, async active-low reset.
- irq_in  in  8  raw request lines, asynchronous to clk.
- mask  in  8  per-line mask, 1 = masked; synchronous to clk.
- pend_vec  out  8  pending & ~mask (combinational from the pending register and mask); feeds the encoder's data_in.
- enc_idx  in  3  encoder's data_out; valid whenever pend_vec != 0.
- req_valid  out  1  offered interrupt index is valid.
- req_idx  out  3  offered interrupt index.
- req_ready  in  1  consumer accepts the offer.
- eoi  in  1  single-cycle end-of-interrupt pulse.
- pending  out  8  raw pending register, unmasked.
- in_service  out  8  one-hot in-service line; all zero when none is in service.

## Operation
- Synchroniser: SYNC_STAGES flops per line, followed by a prev flop for edge detection. All reset to 0.
- Pending set condition:
  - EDGE=1: sync & ~prev.
  - EDGE=0: sync.
  - Masked lines still set pending; the mask only gates pend_vec.
- Pending clear: on handshake (req_valid & req_ready), clear pending[req_idx].
  - A set and a clear on the same bit in the same cycle: set wins, and the bit stays 1.
- A second edge on an already-pending line is absorbed. There is no counting.
- FSM states: IDLE, OFFER, SERVICE. Reset state is IDLE.
- IDLE:
  - If pend_vec != 0, capture enc_idx into req_idx and go to OFFER.
  - eoi is ignored.
- OFFER:
  - req_valid=1. req_idx is held stable until the handshake, even if a higher-priority line arrives or the offered line becomes masked. There is no preemption and no withdrawal.
  - On req_ready: clear pending[req_idx], set in_service to one-hot(req_idx), go to SERVICE.
  - eoi is ignored.
- SERVICE:
  - req_valid=0.
  - On eoi: in_service=0, go to IDLE.
  - New requests keep latching, including on the in-service line itself; that line is offered again after the eoi.
- Reset values: req_valid=0, req_idx=0, pending=0, in_service=0, pend_vec=0 (independent of mask).
- Reset mid-operation: all state clears immediately. Outstanding offers and service are lost without any eoi.
- Reset release: in EDGE=1 mode, a line held high through reset release produces exactly one pending set, because prev resets to 0.

## Timing
- Request to pending (EDGE=1): irq_in first sampled high at edge N; pending bit set at edge N+SYNC_STAGES.
- pend_vec follows pending and mask combinationally. The encoder is combinational, so enc_idx is valid in the same cycle.
- Pending to offer: req_valid rises at the next edge. The default total is 4 edges from the first sample of irq_in.
- Handshake completes on any edge where req_valid & req_ready are both high. req_ready may be held high in advance, giving a 1-cycle OFFER.
- SERVICE to IDLE: eoi sampled at edge M gives IDLE at M.
- The next offer can then appear at edge M+1 at the earliest.
- Throughput: at most one interrupt per offer/service/eoi round, minimum 3 cycles.

## Test plan
- Reset with irq_in=0 → all outputs 0. Pulse irq_in[3] for 1 cycle, mask=0, req_ready=1 → pending[3] at edge 3, req_valid with req_idx=3 at edge 4, handshake clears pending[3] and sets in_service=8'b0000_1000.
- Set irq_in[2] and irq_in[6] in the same cycle → req_idx=6 first. After eoi, req_idx=2 is offered. pending=0 at the end.
- Keep req_ready=0 and offer idx 2, then raise irq_in[7] → req_idx stays 2 until the handshake. After eoi, idx 7 is offered.
- mask=8'b0001_0000 and pulse irq_in[4] → pending[4]=1, pend_vec=0, req_valid stays 0. Clear the mask → offer idx 4 one edge later.
- EDGE=0, hold irq_in[1] high across a handshake → pending[1] remains 1 (set wins). idx 1 is offered again immediately after eoi.
- Assert rst_n low during SERVICE with irq_in[5] held high → outputs are 0 immediately. After release, exactly one offer of idx 5 (EDGE=1).
